ov7670_video_timing: RTL
========================

Name: ov7670_video_timing

Overview:
Sits between the OV7670 byte bus and the video-in port of the block design, one instance per camera (left/right).
Pairs camera bytes into 16-bit YUV422 words and regenerates clean, aligned active_video/hblank/hsync/vblank/vsync from raw href/vsync.
Counts pixels and lines, and flags malformed lines and frames so that PS software can reject a bad stereo frame.

Parameters:
H_ACTIVE, 640, expected pixels (byte pairs) per line
V_ACTIVE, 480, expected lines per frame
HSYNC_W, 4, hsync pulse width in clk cycles (1..15)
BYTE_SWAP, 0, 0: pixel = {first byte, second byte}; 1: pixel = {second, first}

Ports:
clk  in  1  camera pixel clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
din  in  8  camera data byte
href  in  1  camera line-valid
vsync  in  1  camera frame sync, high = vertical blank
clr_err  in  1  synchronous clear of sticky error flags
vid_data  out  16  assembled pixel
vid_valid  out  1  one-cycle strobe, vid_data valid
vid_active  out  1  active video, aligned to vid_data
vid_hblank  out  1  inverse of vid_active outside vblank
vid_hsync  out  1  HSYNC_W-cycle pulse at end of each line
vid_vblank  out  1  registered vsync, aligned
vid_vsync  out  1  registered vsync, aligned
pixel_count  out  11  pixels in current line, saturates at 2047
line_count  out  10  lines in current frame, saturates at 1023
frame_done  out  1  one-cycle pulse at vsync rising edge
err_line  out  1  sticky: line length != H_ACTIVE or odd byte count
err_frame  out  1  sticky: line count != V_ACTIVE

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM in VBLANK, counters 0.
- Input stage: din/href/vsync registered once (din_q, href_q, vsync_q); all edge detection uses the registered copies.
- FSM states:
  - VBLANK: vsync_q=1 → stay; vsync_q=0 → IDLE.
  - IDLE: href_q=1 → B0 (capture byte 0).
  - B0 → B1 when href_q=1, capturing byte 1. In B1, emit the pixel and return to B0 if href_q=1.
  - href_q falls in B0 or B1 → HEND.
  - HEND: hsync counter runs HSYNC_W cycles, then → IDLE.
  - vsync_q=1 in any state → VBLANK; this overrides everything.
- Latency: the byte sampled by din_q at edge k pairs with the byte at edge k+1. vid_data and vid_valid=1 register at edge k+2. vid_valid is never high on consecutive cycles.
- vid_active = href_q delayed one cycle; vid_hblank = ~vid_active & ~vid_vblank.
- Odd byte count: href falls while in B1-pending (byte 0 held) → lone byte dropped, no vid_valid, err_line set.
- vid_hsync: asserts the cycle after the href_q falling edge for exactly HSYNC_W cycles. A new href rising edge during HEND is ignored until HEND exits; those bytes are lost and err_line is set.
- pixel_count: +1 per vid_valid; cleared on the first byte of the next line; holds its value through HEND.
- Line end: at the href_q falling edge, line_count +1 (saturating). If pixel_count != H_ACTIVE, err_line set.
- Frame end: at the vsync_q rising edge, frame_done pulses 1 cycle. If line_count != V_ACTIVE, err_frame set. line_count clears on the following cycle.
- href_q while vsync_q=1: ignored; no strobes, no counting.
- clr_err=1: clears err_line/err_frame. A simultaneous set event wins (flag stays 1).
- Reset mid-line: immediate return to VBLANK; the partial pixel is discarded.

Optional Feature:
OV_TEST_PATTERN_EN
- Defined: adds input test_en (1 bit). When test_en=1, vid_data = {pixel_count[7:0], 8'h80}, a horizontal luma ramp with neutral chroma. Timing, strobes and counters are unchanged.
- Not defined: port absent; vid_data is always camera data.

Decomposition:
- Package ov_video_pkg holds:
  - FSM state enum (VBLANK, IDLE, B0, B1, HEND)
  - width constants PIX_CNT_W=11, LINE_CNT_W=10
  - default H_ACTIVE/V_ACTIVE
- Sub-module ov_byte_pair: byte phase toggle, pixel assembly, BYTE_SWAP, odd-byte detect. Outputs word + strobe + odd flag.

Test Plan:
- 640-pixel line (1280 bytes, din=0x10,0x20 repeating), BYTE_SWAP=0 → 640 vid_valid strobes, each vid_data=0x1020 two cycles after its byte 1; pixel_count=640; err_line=0; vid_hsync high 4 cycles after href falls.
- Full frame of 480 such lines, then vsync rise → frame_done single pulse; line_count=480 before clear then 0; err_frame=0.
- Line of 1279 bytes → 639 strobes, last byte dropped, err_line=1. clr_err pulse → err_line=0. clr_err coincident with a new short line → err_line stays 1.
- Frame of 479 lines → err_frame=1 at vsync rise. href pulses during vsync high → zero strobes, line_count unchanged.
- reset low mid-line (after 300 pixels) → all outputs 0 asynchronously. Next frame counts from 0 with no spurious strobe.
- OV_TEST_PATTERN_EN defined, test_en=1 → pixel n gives vid_data={n[7:0],0x80}, e.g. pixel 5 → 0x0580; strobe timing identical to camera mode.

Source files
------------

// File: rtl/ov_video_pkg.sv
// Shared types and constants for the OV7670 video timing front end.
package ov_video_pkg;

  // Line-capture states: B0 = first byte of a pair held, B1 = pair just completed.
  typedef enum logic [2:0] {
    VBLANK = 3'd0,
    IDLE   = 3'd1,
    B0     = 3'd2,
    B1     = 3'd3,
    HEND   = 3'd4
  } state_t;

  localparam int PIX_CNT_W    = 11;
  localparam int LINE_CNT_W   = 10;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // Counters stop at all-ones so a runaway line/frame cannot wrap back to a plausible value.
  function automatic logic [PIX_CNT_W-1:0] sat_inc_pix(input logic [PIX_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [LINE_CNT_W-1:0] sat_inc_line(input logic [LINE_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ov_byte_pair.sv
// Pairs consecutive camera bytes into one 16-bit YUV422 word.
// The phase bit tracks whether the first byte of a pair is being held; a line
// that ends with the phase set had an odd byte count and its lone byte is dropped.
module ov_byte_pair #(
  parameter bit BYTE_SWAP = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  din_q,
  input  logic        take,
  input  logic        flush,
  output logic [15:0] word,
  output logic        strobe,
  output logic        odd
);

  logic       phase;
  logic [7:0] hold;

  // Toggle the phase on every accepted byte and park the first byte of each pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= 1'b0;
      hold  <= 8'h00;
    end else if (flush) begin
      phase <= 1'b0;
    end else if (take) begin
      phase <= ~phase;
      if (!phase) hold <= din_q;
    end
  end

  // Word is complete when the second byte arrives while the first is held.
  always_comb begin
    word   = BYTE_SWAP ? {din_q, hold} : {hold, din_q};
    strobe = take & phase;
    odd    = phase;
  end

endmodule

// File: rtl/ov7670_video_timing.sv
// OV7670 byte bus to video-in adapter: pairs bytes into YUV422 words,
// regenerates aligned active/blank/sync, counts pixels and lines, and keeps
// sticky flags for malformed lines and frames.
// Build option OV_TEST_PATTERN_EN adds input test_en, which replaces the
// camera data with a horizontal luma ramp {pixel number, 8'h80}.
module ov7670_video_timing
  import ov_video_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int HSYNC_W   = 4,
  parameter bit BYTE_SWAP = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            din,
  input  logic                  href,
  input  logic                  vsync,
`ifdef OV_TEST_PATTERN_EN
  input  logic                  test_en,
`endif
  input  logic                  clr_err,
  output logic [15:0]           vid_data,
  output logic                  vid_valid,
  output logic                  vid_active,
  output logic                  vid_hblank,
  output logic                  vid_hsync,
  output logic                  vid_vblank,
  output logic                  vid_vsync,
  output logic [PIX_CNT_W-1:0]  pixel_count,
  output logic [LINE_CNT_W-1:0] line_count,
  output logic                  frame_done,
  output logic                  err_line,
  output logic                  err_frame
);

  localparam logic [3:0]            HS_LAST = 4'(HSYNC_W - 1);
  localparam logic [PIX_CNT_W-1:0]  H_EXP   = PIX_CNT_W'(H_ACTIVE);
  localparam logic [LINE_CNT_W-1:0] V_EXP   = LINE_CNT_W'(V_ACTIVE);

  logic [7:0]           din_q;
  logic                 href_q;
  logic                 vsync_q;
  state_t               state;
  state_t               state_next;
  logic                 take;
  logic                 line_end;
  logic                 flush;
  logic [3:0]           hs_cnt;
  logic [15:0]          pair_word;
  logic                 pair_done;
  logic                 pair_odd;
  logic [15:0]          pix_word;
  logic [PIX_CNT_W-1:0] pc_inc;
  logic                 vsync_rise;
  logic                 line_bad;
  logic                 hend_overlap;

  // Register the raw camera inputs once; every edge decision uses these copies.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      din_q   <= 8'h00;
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values together.
      din_q   <= din;
      href_q  <= href;
      vsync_q <= vsync;
    end
  end

  // State register; reset parks the FSM in vertical blank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= VBLANK;
    else        state <= state_next;
  end

  // Next state plus per-edge byte-accept and line-end decisions.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_next = state;
    take       = 1'b0;
    line_end   = 1'b0;
    if (vsync_q) begin
      state_next = VBLANK;
    end else begin
      unique case (state)
        VBLANK: state_next = IDLE;
        IDLE: begin
          if (href_q) begin
            take       = 1'b1;
            state_next = B0;
          end
        end
        B0: begin
          if (href_q) begin
            take       = 1'b1;
            state_next = B1;
          end else begin
            line_end   = 1'b1;
            state_next = HEND;
          end
        end
        B1: begin
          if (href_q) begin
            take       = 1'b1;
            state_next = B0;
          end else begin
            line_end   = 1'b1;
            state_next = HEND;
          end
        end
        HEND: begin
          if (hs_cnt == HS_LAST) state_next = IDLE;
        end
        default: state_next = VBLANK;
      endcase
    end
  end

  // Any vertical blank or line end discards a half-assembled pair.
  assign flush = vsync_q | line_end;

  ov_byte_pair #(
    .BYTE_SWAP (BYTE_SWAP)
  ) u_byte_pair (
    .clk    (clk),
    .reset  (reset),
    .din_q  (din_q),
    .take   (take),
    .flush  (flush),
    .word   (pair_word),
    .strobe (pair_done),
    .odd    (pair_odd)
  );

  assign pc_inc = sat_inc_pix(pixel_count);

`ifdef OV_TEST_PATTERN_EN
  assign pix_word = test_en ? {pc_inc[7:0], 8'h80} : pair_word;
`else
  assign pix_word = pair_word;
`endif

  assign vsync_rise   = vsync_q & ~vid_vsync;
  assign line_bad     = line_end & (pair_odd | (pixel_count != H_EXP));
  assign hend_overlap = (state == HEND) & href_q & ~vid_active & ~vsync_q;

  // Hsync width counter, running only while the FSM sits in HEND.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              hs_cnt <= 4'd0;
    else if (state != HEND)  hs_cnt <= 4'd0;
    else                     hs_cnt <= hs_cnt + 4'd1;
  end

  // Video outputs, all one register stage behind the sampled inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid_data   <= 16'h0000;
      vid_valid  <= 1'b0;
      vid_active <= 1'b0;
      vid_hblank <= 1'b0;
      vid_hsync  <= 1'b0;
      vid_vblank <= 1'b0;
      vid_vsync  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vid_valid  <= pair_done;
      if (pair_done) vid_data <= pix_word;
      vid_active <= href_q;
      vid_hblank <= ~href_q & ~vsync_q;
      vid_hsync  <= (state_next == HEND);
      vid_vblank <= vsync_q;
      vid_vsync  <= vsync_q;
      frame_done <= vsync_rise;
    end
  end

  // Pixel and line counters; line count is read out with frame_done, then cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_count <= '0;
      line_count  <= '0;
    end else begin
      if (state == IDLE && take) pixel_count <= '0;
      else if (pair_done)        pixel_count <= pc_inc;
      if (frame_done)            line_count  <= '0;
      else if (line_end)         line_count  <= sat_inc_line(line_count);
    end
  end

  // Sticky error flags; a set event in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_line  <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      err_line  <= line_bad | hend_overlap | (err_line & ~clr_err);
      err_frame <= (vsync_rise & (line_count != V_EXP)) | (err_frame & ~clr_err);
    end
  end

endmodule
